// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control sequencer
//
// Holds the state encoding, the instruction-class codes, the ALUop codes,
// the fixed widths and the packed control bundle used by mc_ctrl_fsm.
package mc_ctrl_pkg;

    localparam int STATE_W = 3;
    localparam int INSTR_W = 4;
    localparam int ALUOP_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [INSTR_W-1:0] IC_NOP  = 4'd0;
    localparam logic [INSTR_W-1:0] IC_ADDU = 4'd1;
    localparam logic [INSTR_W-1:0] IC_SUBU = 4'd2;
    localparam logic [INSTR_W-1:0] IC_ORI  = 4'd3;
    localparam logic [INSTR_W-1:0] IC_LW   = 4'd4;
    localparam logic [INSTR_W-1:0] IC_SW   = 4'd5;
    localparam logic [INSTR_W-1:0] IC_BEQ  = 4'd6;
    localparam logic [INSTR_W-1:0] IC_LUI  = 4'd7;
    localparam logic [INSTR_W-1:0] IC_JAL  = 4'd8;
    localparam logic [INSTR_W-1:0] IC_JR   = 4'd9;
    localparam logic [INSTR_W-1:0] IC_J    = 4'd10;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 3'd2;
    localparam logic [ALUOP_W-1:0] ALU_LUI = 3'd3;

    typedef struct packed {
        logic               mem_req;
        logic               iord;
        logic               pc_write;
        logic               ir_write;
        logic               reg_write;
        logic               reg_dst;
        logic               alu_src;
        logic               branch;
        logic               mem_write;
        logic               mem_to_reg;
        logic               ext_op;
        logic               write_r31;
        logic               jump;
        logic               jump_to_reg;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    // Classes above J are illegal and are executed as NOP.
    function automatic logic [INSTR_W-1:0] legalize(input logic [INSTR_W-1:0] c);
        return (c > IC_J) ? IC_NOP : c;
    endfunction

endpackage

// File: rtl/mc_perf_cnt.sv
// rtl/mc_perf_cnt.sv - cycle and retired-instruction counters for mc_ctrl_fsm
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   retire         : one-cycle pulse when an instruction retires (already reset-gated)
//   cyc_cnt        : non-reset cycles seen, wraps modulo 2^32
//   ins_cnt        : retired instructions, wraps modulo 2^32
module mc_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        retire,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ins_cnt
);

    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] ins_cnt_q, ins_cnt_d;

    always_comb begin
        cyc_cnt_d = cyc_cnt_q + 32'd1;
        ins_cnt_d = ins_cnt_q + {31'd0, retire};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt_q <= '0;
            ins_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            ins_cnt_q <= ins_cnt_d;
        end
    end

    assign cyc_cnt = cyc_cnt_q;
    assign ins_cnt = ins_cnt_q;

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
//
// Steps each instruction class through the multi-cycle datapath, driving the
// single-cycle control bundle plus PC/IR write strobes and a unified memory
// request (mem_req/IorD, completed by mem_ready).
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   instr[3:0]          : instruction class, sampled in DECODE
//   zero                : ALU zero flag, used by BEQ in EXEC
//   mem_ready           : memory access completes in the cycle it is high
//   mem_req, IorD       : memory request and address select (0 PC, 1 ALU)
//   PCWrite, IRWrite    : PC / IR write strobes
//   RegWrite ... JumpToReg, ALUop[2:0] : datapath controls
//   state[2:0]          : current state (debug)
//   cyc_cnt, ins_cnt    : performance counters
//
// Build option: MC_PERF_CNT_EN instantiates mc_perf_cnt; otherwise the
// counters are constant 0.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               IorD,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               ALUSrc,
    output logic               Branch,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               EXTop,
    output logic               writeR31,
    output logic               Jump,
    output logic               JumpToReg,
    output logic [ALUOP_W-1:0] ALUop,
    output logic [STATE_W-1:0] state,
    output logic [31:0]        cyc_cnt,
    output logic [31:0]        ins_cnt
);

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] class_q, class_d;
    ctrl_t              ctrl;

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        ctrl    = '0;

        case (state_q)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                if (mem_ready) begin
                    ctrl.pc_write = 1'b1;
                    ctrl.ir_write = 1'b1;
                    state_d       = S_DECODE;
                end
            end

            S_DECODE: begin
                class_d = legalize(instr);
                state_d = (legalize(instr) == IC_NOP) ? S_FETCH : S_EXEC;
            end

            S_EXEC: begin
                state_d = S_FETCH;
                case (class_q)
                    IC_ADDU: begin
                        ctrl.reg_dst = 1'b1;
                        ctrl.alu_op  = ALU_ADD;
                        state_d      = S_WB;
                    end
                    IC_SUBU: begin
                        ctrl.reg_dst = 1'b1;
                        ctrl.alu_op  = ALU_SUB;
                        state_d      = S_WB;
                    end
                    IC_ORI: begin
                        ctrl.alu_src = 1'b1;
                        ctrl.alu_op  = ALU_OR;
                        state_d      = S_WB;
                    end
                    IC_LUI: begin
                        ctrl.alu_src = 1'b1;
                        ctrl.alu_op  = ALU_LUI;
                        state_d      = S_WB;
                    end
                    IC_LW, IC_SW: begin
                        ctrl.alu_src = 1'b1;
                        ctrl.ext_op  = 1'b1;
                        ctrl.alu_op  = ALU_ADD;
                        state_d      = S_MEM;
                    end
                    IC_BEQ: begin
                        ctrl.alu_op   = ALU_SUB;
                        ctrl.branch   = 1'b1;
                        ctrl.pc_write = zero;
                    end
                    IC_J: begin
                        ctrl.jump     = 1'b1;
                        ctrl.pc_write = 1'b1;
                    end
                    IC_JAL: begin
                        ctrl.jump      = 1'b1;
                        ctrl.pc_write  = 1'b1;
                        ctrl.write_r31 = 1'b1;
                        ctrl.reg_write = 1'b1;
                    end
                    IC_JR: begin
                        ctrl.jump_to_reg = 1'b1;
                        ctrl.pc_write    = 1'b1;
                    end
                    default: ;
                endcase
            end

            S_MEM: begin
                ctrl.mem_req   = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.mem_write = (class_q == IC_SW);
                if (mem_ready) begin
                    state_d = (class_q == IC_SW) ? S_FETCH : S_WB;
                end
            end

            S_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = (class_q == IC_ADDU) || (class_q == IC_SUBU);
                ctrl.mem_to_reg = (class_q == IC_LW);
                state_d         = S_FETCH;
            end

            default: state_d = S_FETCH;
        endcase

        // Reset wins over everything: the FETCH state seen during reset must
        // not issue a request, and an abandoned instruction writes nothing.
        if (reset) begin
            ctrl = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            class_q <= IC_NOP;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
        end
    end

    assign mem_req   = ctrl.mem_req;
    assign IorD      = ctrl.iord;
    assign PCWrite   = ctrl.pc_write;
    assign IRWrite   = ctrl.ir_write;
    assign RegWrite  = ctrl.reg_write;
    assign RegDst    = ctrl.reg_dst;
    assign ALUSrc    = ctrl.alu_src;
    assign Branch    = ctrl.branch;
    assign MemWrite  = ctrl.mem_write;
    assign MemtoReg  = ctrl.mem_to_reg;
    assign EXTop     = ctrl.ext_op;
    assign writeR31  = ctrl.write_r31;
    assign Jump      = ctrl.jump;
    assign JumpToReg = ctrl.jump_to_reg;
    assign ALUop     = ctrl.alu_op;
    assign state     = state_q;

`ifdef MC_PERF_CNT_EN
    // An instruction retires whenever a live state hands back to FETCH;
    // the unreachable codes also fall to FETCH but retire nothing.
    logic retire;
    assign retire = !reset && (state_d == S_FETCH) &&
                    (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB});

    mc_perf_cnt u_perf_cnt (
        .clk     (clk),
        .reset   (reset),
        .retire  (retire),
        .cyc_cnt (cyc_cnt),
        .ins_cnt (ins_cnt)
    );
`else
    assign cyc_cnt = '0;
    assign ins_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - scoreboard testbench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

`ifdef MC_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    localparam logic [16:0] REQ  = 17'h10000;
    localparam logic [16:0] IORD = 17'h08000;
    localparam logic [16:0] PCW  = 17'h04000;
    localparam logic [16:0] IRW  = 17'h02000;
    localparam logic [16:0] RW   = 17'h01000;
    localparam logic [16:0] RD   = 17'h00800;
    localparam logic [16:0] AS   = 17'h00400;
    localparam logic [16:0] BR   = 17'h00200;
    localparam logic [16:0] MW   = 17'h00100;
    localparam logic [16:0] M2R  = 17'h00080;
    localparam logic [16:0] EXT  = 17'h00040;
    localparam logic [16:0] R31  = 17'h00020;
    localparam logic [16:0] JMP  = 17'h00010;
    localparam logic [16:0] JRG  = 17'h00008;
    localparam logic [16:0] OSUB = 17'h00001;
    localparam logic [16:0] OOR  = 17'h00002;
    localparam logic [16:0] OLUI = 17'h00003;
    localparam logic [16:0] FET  = REQ | PCW | IRW;

    typedef struct {
        logic [3:0]  instr;
        logic        zero;
        logic        rdy;
        logic        rst;
        logic [2:0]  st;
        logic [16:0] ctl;
    } row_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  instr = 4'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, IorD, PCWrite, IRWrite, RegWrite, RegDst, ALUSrc;
    logic        Branch, MemWrite, MemtoReg, EXTop, writeR31, Jump, JumpToReg;
    logic [2:0]  ALUop, state;
    logic [31:0] cyc_cnt, ins_cnt;
    logic [16:0] ctl;

    int total = 0;
    int bad = 0;
    logic [19:0] sb[$];

    assign ctl = {mem_req, IorD, PCWrite, IRWrite, RegWrite, RegDst, ALUSrc, Branch,
                  MemWrite, MemtoReg, EXTop, writeR31, Jump, JumpToReg, ALUop};

    always #5 clk = ~clk;

    mc_ctrl_fsm u_dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .IorD      (IorD),
        .PCWrite   (PCWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .RegDst    (RegDst),
        .ALUSrc    (ALUSrc),
        .Branch    (Branch),
        .MemWrite  (MemWrite),
        .MemtoReg  (MemtoReg),
        .EXTop     (EXTop),
        .writeR31  (writeR31),
        .Jump      (Jump),
        .JumpToReg (JumpToReg),
        .ALUop     (ALUop),
        .state     (state),
        .cyc_cnt   (cyc_cnt),
        .ins_cnt   (ins_cnt)
    );

    function automatic row_t r(input logic [3:0] i, input logic z, input logic rdy,
                               input logic rst, input logic [2:0] st, input logic [16:0] c);
        row_t x;
        x.instr = i; x.zero = z; x.rdy = rdy; x.rst = rst; x.st = st; x.ctl = c;
        return x;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, and stop mid-cycle
    // where the combinational outputs are settled.
    task automatic apply(input row_t x);
        @(posedge clk);
        #1;
        instr     = x.instr;
        zero      = x.zero;
        mem_ready = x.rdy;
        reset     = x.rst;
        sb.push_back({x.st, x.ctl});
        @(negedge clk);
    endtask

    task automatic test_reset();
        row_t rows[$];
        logic [19:0] want;
        rows.push_back(r(4'd1, 0, 1, 1, 3'd0, 17'h0));
        rows.push_back(r(4'd1, 0, 1, 1, 3'd0, 17'h0));
        foreach (rows[k]) begin
            apply(rows[k]);
            want = sb.pop_front();
            total++;
            if ({state, ctl} !== want) begin
                bad++;
                $display("FAIL reset row %0d: got st=%0d ctl=%h want st=%0d ctl=%h",
                         k, state, ctl, want[19:17], want[16:0]);
            end
        end
        total++;
        if (cyc_cnt !== 32'd0 || ins_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset counters: got cyc=%0d ins=%0d want 0 0", cyc_cnt, ins_cnt);
        end
    endtask

    task automatic test_addu();
        row_t rows[$];
        logic [19:0] want;
        rows.push_back(r(4'd1, 0, 1, 0, 3'd0, FET));
        rows.push_back(r(4'd1, 0, 1, 0, 3'd1, 17'h0));
        rows.push_back(r(4'd1, 0, 1, 0, 3'd2, RD));
        rows.push_back(r(4'd1, 0, 1, 0, 3'd4, RW | RD));
        rows.push_back(r(4'd1, 0, 0, 0, 3'd0, REQ));
        foreach (rows[k]) begin
            apply(rows[k]);
            want = sb.pop_front();
            total++;
            if ({state, ctl} !== want) begin
                bad++;
                $display("FAIL addu row %0d: got st=%0d ctl=%h want st=%0d ctl=%h",
                         k, state, ctl, want[19:17], want[16:0]);
            end
        end
        total++;
        if (ins_cnt !== 32'(PERF)) begin
            bad++;
            $display("FAIL addu ins_cnt: got %0d want %0d", ins_cnt, PERF);
        end
    endtask

    task automatic test_lw_wait();
        row_t rows[$];
        logic [19:0] want;
        rows.push_back(r(4'd4, 0, 1, 0, 3'd0, FET));
        rows.push_back(r(4'd4, 0, 1, 0, 3'd1, 17'h0));
        rows.push_back(r(4'd4, 0, 0, 0, 3'd2, AS | EXT));
        for (int i = 0; i < 3; i++) rows.push_back(r(4'd4, 0, 0, 0, 3'd3, REQ | IORD));
        rows.push_back(r(4'd4, 0, 1, 0, 3'd3, REQ | IORD));
        rows.push_back(r(4'd4, 0, 0, 0, 3'd4, RW | M2R));
        foreach (rows[k]) begin
            apply(rows[k]);
            want = sb.pop_front();
            total++;
            if ({state, ctl} !== want) begin
                bad++;
                $display("FAIL lw row %0d: got st=%0d ctl=%h want st=%0d ctl=%h",
                         k, state, ctl, want[19:17], want[16:0]);
            end
        end
    endtask

    task automatic test_branch_jump();
        row_t rows[$];
        logic [19:0] want;
        rows.push_back(r(4'd6, 1, 1, 0, 3'd0, FET));
        rows.push_back(r(4'd6, 1, 1, 0, 3'd1, 17'h0));
        rows.push_back(r(4'd6, 1, 1, 0, 3'd2, BR | OSUB | PCW));
        rows.push_back(r(4'd6, 0, 1, 0, 3'd0, FET));
        rows.push_back(r(4'd6, 0, 1, 0, 3'd1, 17'h0));
        rows.push_back(r(4'd6, 0, 1, 0, 3'd2, BR | OSUB));
        rows.push_back(r(4'd8, 0, 1, 0, 3'd0, FET));
        rows.push_back(r(4'd8, 0, 1, 0, 3'd1, 17'h0));
        rows.push_back(r(4'd8, 0, 1, 0, 3'd2, JMP | PCW | R31 | RW));
        rows.push_back(r(4'd13, 0, 1, 0, 3'd0, FET));
        rows.push_back(r(4'd13, 0, 1, 0, 3'd1, 17'h0));
        foreach (rows[k]) begin
            apply(rows[k]);
            want = sb.pop_front();
            total++;
            if ({state, ctl} !== want) begin
                bad++;
                $display("FAIL branch row %0d: got st=%0d ctl=%h want st=%0d ctl=%h",
                         k, state, ctl, want[19:17], want[16:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        logic [19:0] want;
        rows.push_back(r(4'd3, 0, 1, 0, 3'd0, FET));
        rows.push_back(r(4'd3, 0, 1, 0, 3'd1, 17'h0));
        rows.push_back(r(4'd3, 0, 1, 0, 3'd2, AS | OOR));
        rows.push_back(r(4'd3, 0, 1, 0, 3'd4, RW));
        rows.push_back(r(4'd7, 0, 1, 0, 3'd0, FET));
        rows.push_back(r(4'd7, 0, 1, 0, 3'd1, 17'h0));
        rows.push_back(r(4'd7, 0, 1, 0, 3'd2, AS | OLUI));
        rows.push_back(r(4'd7, 0, 1, 0, 3'd4, RW));
        rows.push_back(r(4'd2, 0, 1, 0, 3'd0, FET));
        rows.push_back(r(4'd2, 0, 1, 0, 3'd1, 17'h0));
        rows.push_back(r(4'd2, 0, 1, 0, 3'd2, RD | OSUB));
        rows.push_back(r(4'd2, 0, 1, 0, 3'd4, RW | RD));
        rows.push_back(r(4'd10, 0, 1, 0, 3'd0, FET));
        rows.push_back(r(4'd10, 0, 1, 0, 3'd1, 17'h0));
        rows.push_back(r(4'd10, 0, 1, 0, 3'd2, JMP | PCW));
        rows.push_back(r(4'd9, 0, 1, 0, 3'd0, FET));
        rows.push_back(r(4'd9, 0, 1, 0, 3'd1, 17'h0));
        rows.push_back(r(4'd9, 0, 1, 0, 3'd2, JRG | PCW));
        rows.push_back(r(4'd5, 0, 1, 0, 3'd0, FET));
        rows.push_back(r(4'd5, 0, 1, 0, 3'd1, 17'h0));
        rows.push_back(r(4'd5, 0, 1, 0, 3'd2, AS | EXT));
        rows.push_back(r(4'd5, 0, 1, 0, 3'd3, REQ | IORD | MW));
        rows.push_back(r(4'd0, 0, 1, 0, 3'd0, FET));
        rows.push_back(r(4'd0, 0, 1, 0, 3'd1, 17'h0));
        foreach (rows[k]) begin
            apply(rows[k]);
            want = sb.pop_front();
            total++;
            if ({state, ctl} !== want) begin
                bad++;
                $display("FAIL b2b row %0d: got st=%0d ctl=%h want st=%0d ctl=%h",
                         k, state, ctl, want[19:17], want[16:0]);
            end
        end
    endtask

    task automatic test_reset_mid_sw();
        row_t rows[$];
        logic [19:0] want;
        rows.push_back(r(4'd5, 0, 1, 0, 3'd0, FET));
        rows.push_back(r(4'd5, 0, 1, 0, 3'd1, 17'h0));
        rows.push_back(r(4'd5, 0, 1, 0, 3'd2, AS | EXT));
        rows.push_back(r(4'd5, 0, 1, 1, 3'd3, 17'h0));
        rows.push_back(r(4'd5, 0, 0, 0, 3'd0, REQ));
        foreach (rows[k]) begin
            apply(rows[k]);
            want = sb.pop_front();
            total++;
            if ({state, ctl} !== want) begin
                bad++;
                $display("FAIL rst_sw row %0d: got st=%0d ctl=%h want st=%0d ctl=%h",
                         k, state, ctl, want[19:17], want[16:0]);
            end
        end
        total++;
        if (cyc_cnt !== 32'd0 || ins_cnt !== 32'd0) begin
            bad++;
            $display("FAIL rst_sw counters: got cyc=%0d ins=%0d want 0 0", cyc_cnt, ins_cnt);
        end
    endtask

    task automatic test_cnt_wrap();
`ifdef MC_PERF_CNT_EN
        force u_dut.u_perf_cnt.cyc_cnt_q = 32'hFFFF_FFFF;
        #1;
        release u_dut.u_perf_cnt.cyc_cnt_q;
        @(negedge clk);
`else
        repeat (3) @(negedge clk);
`endif
        total++;
        if (cyc_cnt !== 32'd0) begin
            bad++;
            $display("FAIL cnt_wrap: got cyc=%h want 0", cyc_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_addu();
        test_lw_wait();
        test_branch_jump();
        test_back_to_back();
        test_reset_mid_sw();
        test_cnt_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle control sequencer for the MIPS datapath. Takes the decoded instruction class, the ALU zero flag and a memory-ready handshake, and steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the same control bundle the single-cycle `ctrlor` produces, plus per-state write strobes, so one shared ALU and one unified memory port can be reused across cycles.

## Interface
- No parameters. Widths are fixed by `mc_ctrl_pkg`.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instr` in 4: instruction class from `instrDecoder`. Read only in DECODE; stable from IR.
- `zero` in 1: ALU zero flag, sampled in EXEC.
- `mem_ready` in 1: memory handshake; the access completes in the cycle it is high.
- `mem_req` out 1: memory access request.
- `IorD` out 1: address select; 0 = PC, 1 = ALU result.
- `PCWrite`, `IRWrite` out 1: write strobes for PC and IR.
- `RegWrite`, `RegDst`, `ALUSrc`, `Branch`, `MemWrite`, `MemtoReg`, `EXTop`, `writeR31`, `Jump`, `JumpToReg` out 1: datapath controls, same meaning as in the single-cycle path.
- `ALUop` out 3: 0 ADD, 1 SUB, 2 OR, 3 LUI.
- `state` out 3: current state, for debug.
- `cyc_cnt`, `ins_cnt` out 32: performance counters. Tied to 0 when the counters are compiled out.

## Operation
- Instruction classes:
  - 0 NOP, 1 ADDU, 2 SUBU, 3 ORI, 4 LW, 5 SW, 6 BEQ, 7 LUI, 8 JAL, 9 JR, 10 J.
  - Classes 11–15 are illegal and handled as NOP.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5–7 are unreachable and go to FETCH.
- FETCH:
  - Assert `mem_req`, with `IorD`=0.
  - Hold while `mem_ready`=0.
  - When `mem_ready`=1: assert `PCWrite` and `IRWrite` (PC←PC+4) and go to DECODE.
- DECODE: latch `instr` into an internal class register.
  - NOP or illegal: go to FETCH. This retires the instruction.
  - Anything else: go to EXEC.
- EXEC, per class:
  - ADDU and SUBU: `RegDst`=1, `ALUSrc`=0, `ALUop` ADD or SUB; go to WB.
  - ORI: `ALUSrc`=1, `EXTop`=0, `ALUop`=OR; go to WB.
  - LUI: `ALUSrc`=1, `ALUop`=LUI; go to WB.
  - LW and SW: `ALUSrc`=1, `EXTop`=1, `ALUop`=ADD; go to MEM.
  - BEQ: `ALUop`=SUB and `Branch`=1. `PCWrite`=`zero`. Retire.
  - J: `Jump`=1, `PCWrite`=1. Retire.
  - JAL: `Jump`=1, `PCWrite`=1, `writeR31`=1, `RegWrite`=1. Retire.
  - JR: `JumpToReg`=1, `PCWrite`=1. Retire.
- MEM:
  - Assert `mem_req` with `IorD`=1; `MemWrite`=1 for SW.
  - Hold while `mem_ready`=0.
  - When `mem_ready`=1: SW retires; LW goes to WB.
- WB:
  - `RegWrite`=1. `MemtoReg`=1 for LW.
  - Destination: `RegDst` for ADDU/SUBU, rt otherwise.
  - Retire.
- Retire means the next state is FETCH.
- All outputs except `state` and the counters are combinational decodes of the state and the class register. Any control not listed for a state is 0.

## Timing
- Latency with zero wait states:
  - NOP: 2 cycles.
  - BEQ, J, JAL, JR: 3 cycles.
  - ALU and SW: 4 cycles.
  - LW: 5 cycles.
- Each low cycle of `mem_ready` in FETCH or MEM adds one cycle.
- `mem_req` stays high and address/controls stay stable until the `mem_ready` cycle. Nothing is committed before that cycle.
- In FETCH or MEM, `mem_ready` is a don't-care in cycles where `mem_req`=0.
- Reset:
  - `state`=FETCH, class register=NOP, counters=0.
  - Every strobe is 0 during the reset cycle, even though the state is FETCH.
  - Reset mid-instruction abandons it with no further writes. Any strobe for that cycle is suppressed.
- A `mem_ready` pulse arriving in the same cycle as `reset` is ignored.

## Configuration
- `MC_PERF_CNT_EN` defined:
  - `cyc_cnt` increments every non-reset cycle.
  - `ins_cnt` increments on every retire.
  - Both wrap modulo 2^32.
- `MC_PERF_CNT_EN` undefined: no counter registers; `cyc_cnt` and `ins_cnt` are constant 0.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state encodings;
  - instruction-class codes;
  - `ALUop` codes;
  - the widths 3/4/3.
- One sub-module, `mc_perf_cnt`: the two counters, instantiated only under the macro.
- The FSM and the output decode stay in `mc_ctrl_fsm`.

## Test plan
- Reset held 2 cycles, then released with `instr`=ADDU and `mem_ready`=1:
  - `state` reads 0,1,2,4,0.
  - `RegWrite`=1 only in the WB cycle.
  - `ins_cnt`=1 after retire.
- LW with `mem_ready` low for 3 cycles in MEM:
  - 8-cycle instruction.
  - `mem_req`=1 and `IorD`=1 are stable for 4 cycles.
  - `MemtoReg`=`RegWrite`=1 in WB.
- BEQ:
  - with `zero`=1: `PCWrite`=1 in EXEC;
  - with `zero`=0: `PCWrite`=0;
  - both cases retire after 3 cycles.
- JAL: in EXEC, `Jump`, `writeR31`, `RegWrite` and `PCWrite` are all 1. `instr`=13 (illegal) retires in 2 cycles with no writes.
- `reset` asserted in the MEM cycle of an SW with `mem_ready`=1:
  - `MemWrite` is 0 in that cycle;
  - the next state is FETCH;
  - counters read 0.
- Counter wrap (macro on): preload `cyc_cnt`=0xFFFFFFFF by force; it reads 0 on the next cycle.
